// File: rtl/bfm_axi_mem_slave.sv
// -----------------------------------------------------------------------------
// bfm_axi_mem_slave
//
// AXI4 slave responder backed by an internal word memory. It terminates the
// master traffic of the USB-to-AXI BFM path so host transactions can run
// without a real peripheral. One burst (write or read) is served at a time;
// AW and AR are arbitrated round-robin when both are requesting.
//
// Ports
//   ACLK, ARESET              clock, synchronous active-high reset
//   AW*  (ID/ADDR/LEN/SIZE/BURST/VALID -> READY)   write command
//   W*   (DATA/STRB/LAST/VALID -> READY)           write data (WID ignored)
//   B*   (ID/RESP/VALID <- READY)                  write response
//   AR*  (ID/ADDR/LEN/SIZE/BURST/VALID -> READY)   read command
//   R*   (ID/DATA/RESP/LAST/VALID <- READY)        read data
//   LOCK/CACHE/PROT/QOS/REGION on both command channels are ignored.
// -----------------------------------------------------------------------------
module bfm_axi_mem_slave #(
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int ADDR_LENGTH  = 12
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [AXI_WIDTH_ID-1:0]   AWID,
    input  logic [AXI_WIDTH_AD-1:0]   AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWLOCK,
    input  logic [3:0]                AWCACHE,
    input  logic [2:0]                AWPROT,
    input  logic [3:0]                AWQOS,
    input  logic [3:0]                AWREGION,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [AXI_WIDTH_ID-1:0]   WID,
    input  logic [AXI_WIDTH_DA-1:0]   WDATA,
    input  logic [AXI_WIDTH_DA/8-1:0] WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [AXI_WIDTH_ID-1:0]   BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [AXI_WIDTH_ID-1:0]   ARID,
    input  logic [AXI_WIDTH_AD-1:0]   ARADDR,
    input  logic [7:0]                ARLEN,
    input  logic [2:0]                ARSIZE,
    input  logic [1:0]                ARBURST,
    input  logic                      ARLOCK,
    input  logic [3:0]                ARCACHE,
    input  logic [2:0]                ARPROT,
    input  logic [3:0]                ARQOS,
    input  logic [3:0]                ARREGION,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [AXI_WIDTH_ID-1:0]   RID,
    output logic [AXI_WIDTH_DA-1:0]   RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY
);

    localparam int DEPTH = 1 << (ADDR_LENGTH - 2);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;
    typedef enum logic {GRANT_WR, GRANT_RD} grant_t;

    state_t                  state;
    grant_t                  last_grant;
    logic [AXI_WIDTH_ID-1:0] id_q;
    logic [AXI_WIDTH_AD-1:0] addr_q;
    logic [7:0]              len_q;
    logic [7:0]              cnt_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    err_q;
    logic                    werr_q;
    logic [AXI_WIDTH_DA-1:0] mem [DEPTH];

    // Illegal size, reserved burst type, or a WRAP length that is not 2/4/8/16.
    function automatic logic cmd_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'd2) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    // Address of the following beat. WRAP keeps the bits above the aligned
    // (LEN+1)<<SIZE block and increments only inside it.
    function automatic logic [AXI_WIDTH_AD-1:0] next_addr(input logic [AXI_WIDTH_AD-1:0] addr,
                                                          input logic [7:0] len,
                                                          input logic [2:0] size,
                                                          input logic [1:0] burst);
        logic [AXI_WIDTH_AD-1:0] step;
        logic [AXI_WIDTH_AD-1:0] mask;
        logic [AXI_WIDTH_AD-1:0] result;
        step = AXI_WIDTH_AD'(1) << size;
        mask = ((AXI_WIDTH_AD'(len) + AXI_WIDTH_AD'(1)) << size) - AXI_WIDTH_AD'(1);
        case (burst)
            BURST_FIXED: result = addr;
            BURST_WRAP:  result = (addr & ~mask) | ((addr + step) & mask);
            default:     result = addr + step;
        endcase
        return result;
    endfunction

    logic                    in_idle;
    logic                    grant_w;
    logic                    grant_r;
    logic                    w_hs;
    logic                    w_final;
    logic                    ar_err;
    logic [AXI_WIDTH_AD-1:0] addr_nx;

    assign in_idle = (state == IDLE) && !ARESET;
    assign grant_w = AWVALID && (!ARVALID || (last_grant == GRANT_RD));
    assign grant_r = ARVALID && !grant_w;
    assign AWREADY = in_idle && grant_w;
    assign ARREADY = in_idle && grant_r;
    assign WREADY  = (state == WR_DATA) && !ARESET;
    assign w_hs    = WREADY && WVALID;
    assign w_final = (cnt_q == len_q);
    assign ar_err  = cmd_err(ARLEN, ARSIZE, ARBURST);
    assign addr_nx = next_addr(addr_q, len_q, size_q, burst_q);
    assign BID     = id_q;
    assign RID     = id_q;

    // NOTE: the memory array is deliberately left out of reset so that its
    // contents survive ARESET; a reset here would also prevent RAM inference.
    always_ff @(posedge ACLK) begin
        if (w_hs && !err_q) begin
            for (int b = 0; b < AXI_WIDTH_DA / 8; b++) begin
                if (WSTRB[b]) mem[addr_q[ADDR_LENGTH-1:2]][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours (e.g. RLAST vs cnt_q).
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            last_grant <= GRANT_RD;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            werr_q     <= 1'b0;
            BRESP      <= RESP_OKAY;
            BVALID     <= 1'b0;
            RDATA      <= '0;
            RRESP      <= RESP_OKAY;
            RLAST      <= 1'b0;
            RVALID     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (AWREADY) begin
                        id_q       <= AWID;
                        addr_q     <= AWADDR;
                        len_q      <= AWLEN;
                        size_q     <= AWSIZE;
                        burst_q    <= AWBURST;
                        err_q      <= cmd_err(AWLEN, AWSIZE, AWBURST);
                        werr_q     <= 1'b0;
                        cnt_q      <= '0;
                        last_grant <= GRANT_WR;
                        state      <= WR_DATA;
                    end else if (ARREADY) begin
                        id_q       <= ARID;
                        addr_q     <= ARADDR;
                        len_q      <= ARLEN;
                        size_q     <= ARSIZE;
                        burst_q    <= ARBURST;
                        err_q      <= ar_err;
                        cnt_q      <= '0;
                        last_grant <= GRANT_RD;
                        // First beat is fetched on the handshake edge itself.
                        RDATA      <= ar_err ? '0 : mem[ARADDR[ADDR_LENGTH-1:2]];
                        RRESP      <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        RLAST      <= (ARLEN == 8'd0);
                        RVALID     <= 1'b1;
                        state      <= RD_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        addr_q <= addr_nx;
                        cnt_q  <= cnt_q + 8'd1;
                        if (WLAST != w_final) werr_q <= 1'b1;
                        // Beat count, not WLAST, terminates the burst.
                        if (w_final) begin
                            BRESP  <= (err_q || werr_q || !WLAST) ? RESP_SLVERR : RESP_OKAY;
                            BVALID <= 1'b1;
                            state  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        BVALID <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RD_DATA: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID <= 1'b0;
                            RLAST  <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            addr_q <= addr_nx;
                            cnt_q  <= cnt_q + 8'd1;
                            RDATA  <= err_q ? '0 : mem[addr_nx[ADDR_LENGTH-1:2]];
                            RLAST  <= ((cnt_q + 8'd1) == len_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_sideband;
    assign unused_sideband = ^{AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, WID,
                               ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION};

endmodule

// File: tb/tb_bfm_axi_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_bfm_axi_mem_slave
//
// Self-checking bench for bfm_axi_mem_slave. A behavioural byte-level memory
// model predicts every B response and R beat; directed bursts cover the
// headline cases and a randomized phase mixes burst types, sizes and stalls.
// -----------------------------------------------------------------------------
module tb_bfm_axi_mem_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWID, WID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWLOCK, ARLOCK;
    logic [3:0]  AWCACHE, AWQOS, AWREGION, ARCACHE, ARQOS, ARREGION;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    bfm_axi_mem_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS),
        .AWREGION(AWREGION), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
        .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] model_mem [1024];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic        wl [256];
    logic [3:0]  cmd_id;
    int unsigned cmd_addr;
    int          cmd_len, cmd_size, cmd_burst;
    logic [1:0]  bresp_exp;

    function automatic bit model_err(input int len, input int size, input int burst);
        return (size > 2) || (burst == 3) ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    // Byte address of beat i, straight from the burst definitions.
    function automatic int unsigned beat_addr(input int unsigned start, input int len,
                                              input int size, input int burst, input int i);
        int unsigned nb, blk, base;
        nb = 1 << size;
        if (burst == 0) return start;
        if (burst == 2) begin
            blk  = (len + 1) * nb;
            base = start - (start % blk);
            return base + ((start - base) + i * nb) % blk;
        end
        return start + i * nb;
    endfunction

    function automatic int word_of(input int unsigned a);
        return int'((a >> 2) % 1024);
    endfunction

    task automatic set_cmd(input logic [3:0] id, input int unsigned addr, input int len,
                           input int size, input int burst);
        cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
    endtask

    task automatic fill_w(input bit rnd_strb);
        for (int i = 0; i <= cmd_len; i++) begin
            wd[i] = $urandom;
            ws[i] = rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF;
            wl[i] = (i == cmd_len);
        end
    endtask

    // ---------------- channel phases (called at a falling edge) ----------------
    task automatic aw_phase(output int waited);
        waited = 0;
        AWID = cmd_id; AWADDR = cmd_addr; AWLEN = 8'(cmd_len);
        AWSIZE = 3'(cmd_size); AWBURST = 2'(cmd_burst); AWVALID = 1'b1;
        #1;
        while (!AWREADY && waited < 20) begin
            @(negedge ACLK); #1; waited++;
        end
        check("aw_ready", AWREADY, 1'b1);
        @(negedge ACLK);
        AWVALID = 1'b0;
    endtask

    task automatic w_phase();
        bit e, bad;
        int w, t;
        e   = model_err(cmd_len, cmd_size, cmd_burst);
        bad = 0;
        for (int i = 0; i <= cmd_len; i++) begin
            while ($urandom_range(0, 3) == 0) @(negedge ACLK);
            WDATA = wd[i]; WSTRB = ws[i]; WLAST = wl[i]; WVALID = 1'b1;
            #1;
            t = 0;
            while (!WREADY && t < 20) begin
                @(negedge ACLK); #1; t++;
            end
            check("w_ready", WREADY, 1'b1);
            if (wl[i] != (i == cmd_len)) bad = 1;
            if (!e) begin
                w = word_of(beat_addr(cmd_addr, cmd_len, cmd_size, cmd_burst, i));
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model_mem[w][8*b +: 8] = wd[i][8*b +: 8];
            end
            @(negedge ACLK);
            WVALID = 1'b0;
        end
        WLAST = 1'b0;
        bresp_exp = (e || bad) ? 2'b10 : 2'b00;
    endtask

    task automatic b_phase();
        int t = 0;
        BREADY = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge ACLK);
        while (!BVALID && t < 20) begin
            @(negedge ACLK); t++;
        end
        check("b_valid", BVALID, 1'b1);
        check("b_id", BID, cmd_id);
        check("b_resp", BRESP, bresp_exp);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check("b_done", BVALID, 1'b0);
    endtask

    task automatic ar_phase(output int waited);
        waited = 0;
        ARID = cmd_id; ARADDR = cmd_addr; ARLEN = 8'(cmd_len);
        ARSIZE = 3'(cmd_size); ARBURST = 2'(cmd_burst); ARVALID = 1'b1;
        #1;
        while (!ARREADY && waited < 20) begin
            @(negedge ACLK); #1; waited++;
        end
        check("ar_ready", ARREADY, 1'b1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("r_first", RVALID, 1'b1);
    endtask

    function automatic logic [31:0] exp_beat(input int i);
        if (model_err(cmd_len, cmd_size, cmd_burst)) return 32'h0;
        return model_mem[word_of(beat_addr(cmd_addr, cmd_len, cmd_size, cmd_burst, i))];
    endfunction

    // pat: 0 random RREADY, 1 always ready, 2 repeating 1,0,0,1.
    task automatic r_phase(input int pat);
        int  i, t;
        bit  rdy, e;
        logic [3:0] stall = 4'b1001;
        i = 0; t = 0;
        e = model_err(cmd_len, cmd_size, cmd_burst);
        while (i <= cmd_len && t < 400) begin
            case (pat)
                1:       rdy = 1;
                2:       rdy = stall[t % 4];
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            RREADY = rdy;
            check("r_valid", RVALID, 1'b1);
            check("r_data", RDATA, exp_beat(i));
            check("r_last", RLAST, i == cmd_len);
            check("r_resp", RRESP, e ? 2'b10 : 2'b00);
            check("r_id", RID, cmd_id);
            @(negedge ACLK);
            if (rdy) i++;
            t++;
        end
        RREADY = 1'b0;
        check("r_end", RVALID, 1'b0);
    endtask

    task automatic do_write();
        int t;
        aw_phase(t);
        w_phase();
        b_phase();
    endtask

    task automatic do_read(input int pat);
        int t;
        ar_phase(t);
        r_phase(pat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, r;
        ARESET = 1'b1;
        {AWID, WID, ARID} = '0;
        {AWADDR, ARADDR, WDATA} = '0;
        {AWLEN, ARLEN, AWSIZE, ARSIZE, AWBURST, ARBURST} = '0;
        {AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION} = '0;
        {ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION} = '0;
        {WSTRB, WLAST, WVALID, AWVALID, ARVALID, BREADY, RREADY} = '0;
        repeat (3) @(negedge ACLK);
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_rlast", RLAST, 1'b0);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_bresp", BRESP, 2'b00);
        check("rst_wready", WREADY, 1'b0);
        AWVALID = 1'b1; ARVALID = 1'b1;
        #1;
        check("rst_awready", AWREADY, 1'b0);
        check("rst_arready", ARREADY, 1'b0);
        AWVALID = 1'b0; ARVALID = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;

        // Contested grant right after reset: write wins.
        set_cmd(4'h1, 32'h0, 0, 2, 1);
        fill_w(0);
        AWID = cmd_id; AWADDR = cmd_addr; AWLEN = 0; AWSIZE = 2; AWBURST = 1;
        ARID = 4'h2; ARADDR = 32'h0; ARLEN = 0; ARSIZE = 2; ARBURST = 1;
        AWVALID = 1'b1; ARVALID = 1'b1;
        #1;
        check("arb1_aw", AWREADY, 1'b1);
        check("arb1_ar", ARREADY, 1'b0);
        @(negedge ACLK);
        AWVALID = 1'b0; ARVALID = 1'b0;
        w_phase();
        b_phase();

        // Next contested cycle: read wins; pending write is served afterwards.
        AWID = 4'h3; AWADDR = 32'h4; AWLEN = 0; AWSIZE = 2; AWBURST = 1;
        AWVALID = 1'b1; ARVALID = 1'b1;
        #1;
        check("arb2_ar", ARREADY, 1'b1);
        check("arb2_aw", AWREADY, 1'b0);
        @(negedge ACLK);
        ARVALID = 1'b0;
        set_cmd(4'h2, 32'h0, 0, 2, 1);
        check("arb2_rfirst", RVALID, 1'b1);
        r_phase(1);
        set_cmd(4'h3, 32'h4, 0, 2, 1);
        fill_w(0);
        do_write();

        // Fill the whole memory so every later read has a defined value.
        for (int k = 0; k < 64; k++) begin
            set_cmd(4'(k), k * 64, 15, 2, 1);
            fill_w(0);
            do_write();
        end

        // INCR write then back-to-back INCR read.
        set_cmd(4'h5, 32'h100, 3, 2, 1);
        fill_w(0);
        for (int i = 0; i < 4; i++) wd[i] = 32'h11111111 * (i + 1);
        do_write();
        set_cmd(4'h6, 32'h100, 3, 2, 1);
        do_read(1);

        // WRAP write starting mid-block, read back in INCR order.
        set_cmd(4'h7, 32'h10C, 3, 2, 2);
        fill_w(0);
        do_write();
        set_cmd(4'h7, 32'h100, 3, 2, 1);
        do_read(1);

        // Partial strobe merge.
        set_cmd(4'h8, 32'h180, 0, 2, 1);
        fill_w(0);
        wd[0] = 32'hAABBCCDD;
        do_write();
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        do_write();
        do_read(1);

        // Reserved burst read; early WLAST write; illegal WRAP length write.
        set_cmd(4'h9, 32'h200, 1, 2, 3);
        do_read(0);
        set_cmd(4'hA, 32'h200, 1, 2, 1);
        fill_w(0);
        wl[0] = 1'b1; wl[1] = 1'b0;
        do_write();
        set_cmd(4'hB, 32'h300, 2, 2, 2);
        fill_w(0);
        do_write();
        set_cmd(4'hB, 32'h300, 2, 2, 1);
        do_read(0);

        // RREADY stall pattern mid-burst.
        set_cmd(4'hC, 32'h140, 7, 2, 1);
        do_read(2);

        // Reset in the middle of a read burst.
        set_cmd(4'hD, 32'h200, 7, 2, 1);
        ar_phase(t);
        for (int i = 0; i < 2; i++) begin
            RREADY = 1'b1;
            check("rst_mid_data", RDATA, exp_beat(i));
            @(negedge ACLK);
        end
        RREADY = 1'b0;
        ARESET = 1'b1;
        @(negedge ACLK);
        check("rst_mid_rvalid", RVALID, 1'b0);
        check("rst_mid_rlast", RLAST, 1'b0);
        ARESET = 1'b0;
        @(negedge ACLK);
        ar_phase(t);
        check("rst_mid_idle", t, 0);
        r_phase(1);

        // Randomized mix.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            cmd_burst = (r < 2) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            cmd_size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            if (cmd_burst == 2)
                cmd_len = ($urandom_range(0, 7) == 0) ? 2 : (2 << $urandom_range(0, 3)) - 1;
            else
                cmd_len = $urandom_range(0, 15);
            cmd_addr = $urandom_range(0, 4095);
            if ($urandom_range(0, 3) == 0) cmd_addr = cmd_addr | ($urandom & 32'hFFFFF000);
            cmd_id = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                fill_w(1);
                if ($urandom_range(0, 7) == 0) begin
                    r = $urandom_range(0, cmd_len);
                    wl[r] = ~wl[r];
                end
                do_write();
            end else begin
                do_read(0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bfm_axi_mem_slave.md
Name: bfm_axi_mem_slave

Overview:
AXI4 slave responder with an internal word memory. It terminates the AXI master traffic produced by the USB-to-AXI BFM path, so host-side transactions can be tested on the board or in simulation without a real peripheral. A single shared state machine serves one burst at a time, either a write or a read, with round-robin arbitration between the AW and AR channels.

Parameters:
AXI_WIDTH_ID, 4, width of the ID fields.
AXI_WIDTH_AD, 32, address width.
AXI_WIDTH_DA, 32, data width (fixed at 32; WSTRB is 4 bits).
ADDR_LENGTH, 12, number of decoded byte-address bits. Memory depth is 2^(ADDR_LENGTH-2) words.

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous, active-high reset
AWID  in  AXI_WIDTH_ID  write ID
AWADDR  in  AXI_WIDTH_AD  write start address
AWLEN  in  8  beats-1
AWSIZE  in  3  bytes/beat = 1<<AWSIZE
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
AWLOCK/AWCACHE/AWPROT/AWQOS/AWREGION  in  1/4/3/4/4  ignored
AWVALID  in  1 ; AWREADY  out  1
WID  in  AXI_WIDTH_ID  ignored
WDATA  in  32 ; WSTRB  in  4 ; WLAST  in  1 ; WVALID  in  1 ; WREADY  out  1
BID  out  AXI_WIDTH_ID ; BRESP  out  2 ; BVALID  out  1 ; BREADY  in  1
ARID  in  AXI_WIDTH_ID ; ARADDR  in  AXI_WIDTH_AD ; ARLEN  in  8 ; ARSIZE  in  3 ; ARBURST  in  2
ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION  in  1/4/3/4/4  ignored
ARVALID  in  1 ; ARREADY  out  1
RID  out  AXI_WIDTH_ID ; RDATA  out  32 ; RRESP  out  2 ; RLAST  out  1 ; RVALID  out  1 ; RREADY  in  1

Behaviour:
- Reset: all outputs are 0, state is IDLE, last_grant is READ (so the first contested grant goes to write). Memory contents are not reset; they are preserved across reset. Reset during a burst abandons the burst and does not complete any remaining handshakes.
- States: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE:
  - AWREADY = AWVALID & grant_w; ARREADY = ARVALID & grant_r (combinational on the valids).
  - If only one valid is high, that channel is granted.
  - If both are high, grant the channel opposite last_grant.
  - The command is latched at the handshake (ID, address, LEN, SIZE, BURST), the beat counter is cleared, and last_grant is updated.
- Command error check: SIZE>2, or BURST=11, or (WRAP with LEN not in {1,3,7,15}) sets err. An errored command still consumes or produces all beats, but performs no memory access and responds SLVERR (10).
- Address sequencing:
  - FIXED: the address stays constant.
  - INCR: address += 1<<SIZE. Upper bits beyond ADDR_LENGTH wrap silently.
  - WRAP: address wraps within an aligned block of (LEN+1)<<SIZE bytes.
  - Word index = addr[ADDR_LENGTH-1:2]; higher address bits alias.
- WR_DATA:
  - WREADY=1. Each W handshake writes the bytes whose WSTRB bit is set (unless err), advances the address, and increments the count.
  - If WLAST != (count==LEN) on any beat, werr is set.
  - The burst ends on the beat where count==LEN, regardless of WLAST; next state is WR_RESP.
- WR_RESP: BVALID=1, BID=latched ID, BRESP = SLVERR if err|werr, else OKAY. Hold until BREADY, then go to IDLE.
- RD_DATA:
  - RDATA is registered. The memory word is fetched at the AR handshake edge, so RVALID rises the cycle after the AR handshake.
  - On each R handshake, the next beat's word is fetched at the same edge, giving one beat per cycle when RREADY is held high.
  - RVALID/RDATA/RLAST are held stable while RREADY=0.
  - RID = latched ID. RLAST=1 on beat LEN. RRESP = SLVERR if err (RDATA=0), else OKAY.
  - After the RLAST handshake, go to IDLE; RVALID=0 the following cycle.
- Only one burst is outstanding at a time. AW/AR are not accepted outside IDLE. The minimum turnaround is one IDLE cycle between bursts.

Test Plan:
- Write INCR, AWADDR=0x100, LEN=3, data 0x11111111..0x44444444, WSTRB=F -> BRESP=00, BID=AWID; read INCR, ARADDR=0x100, LEN=3 with RREADY=1 -> 4 consecutive beats returning the same data, RLAST only on beat 3, first RVALID 1 cycle after ARREADY.
- WRAP write, AWADDR=0x10C, LEN=3, SIZE=2 -> writes land at 0x10C, 0x100, 0x104, 0x108; INCR read back from 0x100 confirms the order.
- Partial strobe: preload 0xAABBCCDD, write 0x11223344 with WSTRB=0101 -> read returns 0xAA22CC44.
- AWVALID and ARVALID asserted in the same cycle after reset -> write granted first; next contested IDLE cycle -> read granted.
- Error cases: ARBURST=11, LEN=1 -> 2 beats with RRESP=10, RDATA=0. Write with WLAST early on beat 0 of LEN=1 -> 2 beats accepted, BRESP=10.
- RREADY toggled 1,0,0,1 mid-burst -> RDATA/RLAST held stable while stalled. ARESET pulsed mid read burst -> RVALID=0 next cycle, state IDLE, and memory still holds the prior data.
